debounce_bank: RTL and testbench



---
 rtl/debounce_bank.sv | 165 ++++++++++++++++
 tb/tb_debounce_bank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel two-flop synchroniser, counting filter FSM,
// registered level plus rise/fall pulses. Define DEBOUNCE_REPEAT_EN for auto-repeat pulses.
module debounce_bank #(
  parameter int CHANNELS = 4,
  parameter int N        = 19,
  parameter int REPEAT_N = 23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt
);

  typedef enum logic [1:0] {
    STABLE_ZERO = 2'b00,
    ZERO_TO_ONE = 2'b01,
    STABLE_ONE  = 2'b10,
    ONE_TO_ZERO = 2'b11
  } state_e;

  localparam logic [N-1:0] M = {N{1'b1}};

  if (N < 1 || REPEAT_N < 1) begin : g_bad_params
    $error("debounce_bank: N and REPEAT_N must be at least 1");
  end

  logic [CHANNELS-1:0] s1_q, s1_d;
  logic [CHANNELS-1:0] s_q, s_d;
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [N-1:0]        cnt_q   [CHANNELS];
  logic [N-1:0]        cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

  always_comb begin
    s1_d = raw;
    s_d  = s1_q;
  end

  // NOTE: every signal written here gets a default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    q_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE_ZERO: begin
          if (s_q[i]) begin
            state_d[i] = ZERO_TO_ONE;
            cnt_d[i]   = M;
          end
        end
        ZERO_TO_ONE: begin
          if (!s_q[i]) begin
            state_d[i] = STABLE_ZERO;
          end else begin
            cnt_d[i] = cnt_q[i] - N'(1);
            if (cnt_q[i] == N'(1)) begin
              state_d[i] = STABLE_ONE;
              rise_d[i]  = 1'b1;
            end
          end
        end
        STABLE_ONE: begin
          if (!s_q[i]) begin
            state_d[i] = ONE_TO_ZERO;
            cnt_d[i]   = M;
          end
        end
        ONE_TO_ZERO: begin
          if (s_q[i]) begin
            state_d[i] = STABLE_ONE;
          end else begin
            cnt_d[i] = cnt_q[i] - N'(1);
            if (cnt_q[i] == N'(1)) begin
              state_d[i] = STABLE_ZERO;
              fall_d[i]  = 1'b1;
            end
          end
        end
        default: state_d[i] = STABLE_ZERO;
      endcase
      // q is registered from the next state so it changes on the same edge as rise/fall.
      q_d[i] = (state_d[i] == STABLE_ONE) || (state_d[i] == ONE_TO_ZERO);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s_q    <= '0;
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= STABLE_ZERO;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      s_q    <= s_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  logic [REPEAT_N-1:0] rcnt_q [CHANNELS];
  logic [REPEAT_N-1:0] rcnt_d [CHANNELS];
  logic [CHANNELS-1:0] rpt_q, rpt_d;

  // The repeat counter is armed only by a genuine press; a bounce back from
  // ONE_TO_ZERO resumes the count where it was held.
  always_comb begin
    rpt_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rcnt_d[i] = rcnt_q[i];
      if (state_q[i] == ZERO_TO_ONE && state_d[i] == STABLE_ONE) begin
        rcnt_d[i] = '1;
      end else if (state_q[i] == STABLE_ONE) begin
        if (rcnt_q[i] == '0) begin
          rpt_d[i]  = 1'b1;
          rcnt_d[i] = '1;
        end else begin
          rcnt_d[i] = rcnt_q[i] - REPEAT_N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q <= '0;
      for (int i = 0; i < CHANNELS; i++) rcnt_q[i] <= '0;
    end else begin
      rpt_q <= rpt_d;
      for (int i = 0; i < CHANNELS; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank with N=4 (M=15), CHANNELS=4.
// The repeat scenario runs only when DEBOUNCE_REPEAT_EN is defined.
module tb_debounce_bank;

  logic       clk;
  logic       reset;
  logic [3:0] raw;
  logic [3:0] q, rise, fall, rpt;

  int checks   = 0;
  int failures = 0;
  int rise_cnt [4];
  int fall_cnt [4];
  int rpt_cnt  = 0;

  debounce_bank #(.CHANNELS(4), .N(4), .REPEAT_N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .rpt   (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) rise_cnt[i]++;
      if (fall[i]) fall_cnt[i]++;
    end
    if (rpt[0]) rpt_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    raw   = 4'b0000;
    tick(3);
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=%b", q, 4'b0000); end
    checks++; if (rise !== 4'b0000) begin failures++; $display("FAIL reset_rise got=%b exp=%b", rise, 4'b0000); end
    checks++; if (fall !== 4'b0000) begin failures++; $display("FAIL reset_fall got=%b exp=%b", fall, 4'b0000); end
    checks++; if (rpt !== 4'b0000) begin failures++; $display("FAIL reset_rpt got=%b exp=%b", rpt, 4'b0000); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_clean_press;
    int r0, f0;
    r0 = rise_cnt[0];
    f0 = fall_cnt[0];
    raw[0] = 1'b1;
    tick(17);
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL press_early_q got=%b exp=%b", q, 4'b0000); end
    tick(1);
    checks++; if (q !== 4'b0001) begin failures++; $display("FAIL press_q got=%b exp=%b", q, 4'b0001); end
    checks++; if (rise !== 4'b0001) begin failures++; $display("FAIL press_rise got=%b exp=%b", rise, 4'b0001); end
    checks++; if (fall !== 4'b0000) begin failures++; $display("FAIL press_fall got=%b exp=%b", fall, 4'b0000); end
    checks++; if (rpt !== 4'b0000) begin failures++; $display("FAIL press_rpt got=%b exp=%b", rpt, 4'b0000); end
    tick(1);
    checks++; if (rise !== 4'b0000) begin failures++; $display("FAIL press_rise_drop got=%b exp=%b", rise, 4'b0000); end
    checks++; if (q !== 4'b0001) begin failures++; $display("FAIL press_q_hold got=%b exp=%b", q, 4'b0001); end
    raw[0] = 1'b0;
    tick(17);
    checks++; if (q !== 4'b0001) begin failures++; $display("FAIL release_early_q got=%b exp=%b", q, 4'b0001); end
    tick(1);
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL release_q got=%b exp=%b", q, 4'b0000); end
    checks++; if (fall !== 4'b0001) begin failures++; $display("FAIL release_fall got=%b exp=%b", fall, 4'b0001); end
    checks++; if (rise !== 4'b0000) begin failures++; $display("FAIL release_rise got=%b exp=%b", rise, 4'b0000); end
    tick(1);
    checks++; if (fall !== 4'b0000) begin failures++; $display("FAIL release_fall_drop got=%b exp=%b", fall, 4'b0000); end
    tick(3);
    checks++; if (rise_cnt[0] - r0 !== 1) begin failures++; $display("FAIL press_rise_count got=%0d exp=%0d", rise_cnt[0] - r0, 1); end
    checks++; if (fall_cnt[0] - f0 !== 1) begin failures++; $display("FAIL press_fall_count got=%0d exp=%0d", fall_cnt[0] - f0, 1); end
  endtask

  task automatic test_bounce;
    int r1;
    r1 = rise_cnt[1];
    raw[1] = 1'b1;
    tick(10);
    raw[1] = 1'b0;
    tick(3);
    raw[1] = 1'b1;
    tick(17);
    checks++; if (q[1] !== 1'b0) begin failures++; $display("FAIL bounce_early_q got=%b exp=%b", q[1], 1'b0); end
    tick(1);
    checks++; if (q[1] !== 1'b1) begin failures++; $display("FAIL bounce_q got=%b exp=%b", q[1], 1'b1); end
    checks++; if (rise[1] !== 1'b1) begin failures++; $display("FAIL bounce_rise got=%b exp=%b", rise[1], 1'b1); end
    tick(3);
    checks++; if (rise_cnt[1] - r1 !== 1) begin failures++; $display("FAIL bounce_rise_count got=%0d exp=%0d", rise_cnt[1] - r1, 1); end
    raw[1] = 1'b0;
    tick(22);
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL bounce_cleanup_q got=%b exp=%b", q, 4'b0000); end
  endtask

  task automatic test_glitch;
    int r2, f2;
    raw[2] = 1'b1;
    tick(20);
    checks++; if (q[2] !== 1'b1) begin failures++; $display("FAIL glitch_setup_q got=%b exp=%b", q[2], 1'b1); end
    r2 = rise_cnt[2];
    f2 = fall_cnt[2];
    raw[2] = 1'b0;
    tick(12);
    raw[2] = 1'b1;
    tick(30);
    checks++; if (q[2] !== 1'b1) begin failures++; $display("FAIL glitch_q got=%b exp=%b", q[2], 1'b1); end
    checks++; if (fall_cnt[2] - f2 !== 0) begin failures++; $display("FAIL glitch_fall_count got=%0d exp=%0d", fall_cnt[2] - f2, 0); end
    checks++; if (rise_cnt[2] - r2 !== 0) begin failures++; $display("FAIL glitch_rise_count got=%0d exp=%0d", rise_cnt[2] - r2, 0); end
    raw[2] = 1'b0;
    tick(22);
  endtask

  task automatic test_simultaneous;
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL simul_start_q got=%b exp=%b", q, 4'b0000); end
    raw = 4'b1111;
    tick(17);
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL simul_early_q got=%b exp=%b", q, 4'b0000); end
    tick(1);
    checks++; if (q !== 4'b1111) begin failures++; $display("FAIL simul_q got=%b exp=%b", q, 4'b1111); end
    checks++; if (rise !== 4'b1111) begin failures++; $display("FAIL simul_rise got=%b exp=%b", rise, 4'b1111); end
    tick(1);
    checks++; if (rise !== 4'b0000) begin failures++; $display("FAIL simul_rise_drop got=%b exp=%b", rise, 4'b0000); end
    raw = 4'b0000;
    tick(17);
    checks++; if (fall !== 4'b0000) begin failures++; $display("FAIL simul_early_fall got=%b exp=%b", fall, 4'b0000); end
    tick(1);
    checks++; if (fall !== 4'b1111) begin failures++; $display("FAIL simul_fall got=%b exp=%b", fall, 4'b1111); end
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL simul_release_q got=%b exp=%b", q, 4'b0000); end
    tick(3);
  endtask

  task automatic test_reset_mid_filter;
    raw[0] = 1'b1;
    // ZERO_TO_ONE is entered two edges after the first sample with cnt=15;
    // ten further edges leave cnt=5.
    tick(13);
    #1 reset = 1'b1;
    #1;
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL midrst_q got=%b exp=%b", q, 4'b0000); end
    checks++; if (rise !== 4'b0000) begin failures++; $display("FAIL midrst_rise got=%b exp=%b", rise, 4'b0000); end
    checks++; if (fall !== 4'b0000) begin failures++; $display("FAIL midrst_fall got=%b exp=%b", fall, 4'b0000); end
    tick(1);
    reset = 1'b0;
    tick(17);
    checks++; if (q[0] !== 1'b0) begin failures++; $display("FAIL midrst_early_q got=%b exp=%b", q[0], 1'b0); end
    tick(1);
    checks++; if (q[0] !== 1'b1) begin failures++; $display("FAIL midrst_q_after got=%b exp=%b", q[0], 1'b1); end
    checks++; if (rise[0] !== 1'b1) begin failures++; $display("FAIL midrst_rise_after got=%b exp=%b", rise[0], 1'b1); end
    raw[0] = 1'b0;
    tick(22);
  endtask

`ifdef DEBOUNCE_REPEAT_EN
  task automatic test_repeat;
    int p0;
    raw[0] = 1'b1;
    tick(18);
    checks++; if (rise[0] !== 1'b1) begin failures++; $display("FAIL rpt_rise got=%b exp=%b", rise[0], 1'b1); end
    tick(7);
    checks++; if (rpt[0] !== 1'b0) begin failures++; $display("FAIL rpt_early got=%b exp=%b", rpt[0], 1'b0); end
    tick(1);
    checks++; if (rpt[0] !== 1'b1) begin failures++; $display("FAIL rpt_8 got=%b exp=%b", rpt[0], 1'b1); end
    tick(1);
    checks++; if (rpt[0] !== 1'b0) begin failures++; $display("FAIL rpt_8_drop got=%b exp=%b", rpt[0], 1'b0); end
    tick(7);
    checks++; if (rpt[0] !== 1'b1) begin failures++; $display("FAIL rpt_16 got=%b exp=%b", rpt[0], 1'b1); end
    tick(8);
    checks++; if (rpt[0] !== 1'b1) begin failures++; $display("FAIL rpt_24 got=%b exp=%b", rpt[0], 1'b1); end
    raw[0] = 1'b0;
    tick(18);
    checks++; if (fall[0] !== 1'b1) begin failures++; $display("FAIL rpt_fall got=%b exp=%b", fall[0], 1'b1); end
    tick(2);
    p0 = rpt_cnt;
    tick(40);
    checks++; if (rpt_cnt - p0 !== 0) begin failures++; $display("FAIL rpt_after_release got=%0d exp=%0d", rpt_cnt - p0, 0); end
  endtask
`else
  task automatic test_repeat;
    raw[0] = 1'b1;
    tick(40);
    checks++; if (rpt_cnt !== 0) begin failures++; $display("FAIL rpt_disabled_count got=%0d exp=%0d", rpt_cnt, 0); end
    checks++; if (q[0] !== 1'b1) begin failures++; $display("FAIL rpt_disabled_q got=%b exp=%b", q[0], 1'b1); end
    raw[0] = 1'b0;
    tick(22);
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_filter();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
